// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM encoding, default width,
// and the bit-counter sizing rule.
package serial_adder_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  // Counter must hold 0..WIDTH; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned w);
    int unsigned c;
    c = $clog2(w + 1);
    return (c < 1) ? 1 : c;
  endfunction

endpackage

// File: rtl/serial_adder_if.sv
// Request/result bundle of the serial adder: operands and START in,
// BUSY/DONE status and registered SUM/COUT out.
interface serial_adder_if
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
);
  logic             START;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             BUSY;
  logic             DONE;
  logic [WIDTH-1:0] SUM;
  logic             COUT;

  modport master (output START, A, B, input BUSY, DONE, SUM, COUT);
  modport slave  (input START, A, B, output BUSY, DONE, SUM, COUT);
endinterface

// File: rtl/serial_adder_half_adder.sv
// Single-bit half adder; two of these plus an OR form the serial full adder.
module half_adder (
  input  logic i_a,
  input  logic i_b,
  output logic o_s,
  output logic o_c
);
  assign o_s = i_a ^ i_b;
  assign o_c = i_a & i_b;
endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: LSB-first, one bit per clock, result and carry held
// in output registers until the next completion or reset.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input logic           CLK,
  input logic           RST,
  serial_adder_if.slave bus
);
  localparam int unsigned CW = cnt_width(WIDTH);

  state_t           r_state;
  state_t           w_next;
  logic             w_accept;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_res;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry;
  logic             r_cout;
  logic [CW-1:0]    r_cnt;

  logic             w_s0;
  logic             w_c0;
  logic             w_s;
  logic             w_c1;
  logic             w_cy;
  logic             w_last;
  logic [WIDTH-1:0] w_res_next;

  half_adder u_ha0 (.i_a(r_a[0]), .i_b(r_b[0]),  .o_s(w_s0), .o_c(w_c0));
  half_adder u_ha1 (.i_a(w_s0),   .i_b(r_carry), .o_s(w_s),  .o_c(w_c1));

  assign w_cy   = w_c0 | w_c1;
  assign w_last = (r_cnt == CW'(WIDTH - 1));
  // Shift-based insert keeps WIDTH=1 legal (no zero-width slice).
  assign w_res_next = (r_res >> 1) | (WIDTH'(w_s) << (WIDTH - 1));

  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.START) begin
          w_next   = RUN;
          w_accept = 1'b1;
        end
      end
      RUN: begin
        if (w_last) w_next = FIN;
      end
      FIN: begin
        w_accept = bus.START;
        w_next   = bus.START ? RUN : IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_cnt   <= '0;
    end else if (w_accept) begin
      r_a     <= bus.A;
      r_b     <= bus.B;
      r_res   <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
    end else if (r_state == RUN) begin
      r_a     <= r_a >> 1;
      r_b     <= r_b >> 1;
      r_res   <= w_res_next;
      r_carry <= w_cy;
      r_cnt   <= r_cnt + CW'(1);
      if (w_last) begin
        r_sum  <= w_res_next;
        r_cout <= w_cy;
      end
    end
  end

  assign bus.BUSY = (r_state == RUN);
  assign bus.DONE = (r_state == FIN);
  assign bus.SUM  = r_sum;
  assign bus.COUT = r_cout;

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: WIDTH=8 instance checked every cycle against a
// transaction-level model, plus exhaustive WIDTH=4 and WIDTH=1 instances.
module tb_serial_adder;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  serial_adder_if #(.WIDTH(8)) bus8 ();
  serial_adder_if #(.WIDTH(4)) bus4 ();
  serial_adder_if #(.WIDTH(1)) bus1 ();

  serial_adder #(.WIDTH(8)) u_dut8 (.CLK(clk), .RST(rst), .bus(bus8.slave));
  serial_adder #(.WIDTH(4)) u_dut4 (.CLK(clk), .RST(rst), .bus(bus4.slave));
  serial_adder #(.WIDTH(1)) u_dut1 (.CLK(clk), .RST(rst), .bus(bus1.slave));

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", nm, got, exp, $time);
    end
  endtask

  // Transaction model: an accepted operation completes WIDTH edges later.
  int         m_rem  = 0;
  logic [8:0] m_op   = '0;
  logic [8:0] m_res  = '0;
  logic       m_done = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_rem  = 0;
      m_res  = '0;
      m_done = 1'b0;
    end else begin
      m_done = 1'b0;
      if (m_rem > 0) begin
        m_rem--;
        if (m_rem == 0) begin
          m_res  = m_op;
          m_done = 1'b1;
        end
      end else if (bus8.START) begin
        m_op  = {1'b0, bus8.A} + {1'b0, bus8.B};
        m_rem = 8;
      end
    end
  end

  always @(negedge clk) begin
    check("cyc_busy", 64'(bus8.BUSY), 64'(m_rem > 0));
    check("cyc_done", 64'(bus8.DONE), 64'(m_done));
    check("cyc_sum",  64'(bus8.SUM),  64'(m_res[7:0]));
    check("cyc_cout", 64'(bus8.COUT), 64'(m_res[8]));
  end

  // Starts at posedge+2; returns at posedge+2 in the DONE cycle.
  task automatic run8(input string nm, input logic [7:0] a, input logic [7:0] b,
                      input logic [7:0] es, input logic ec);
    int n;
    int nb;
    bit found;
    bus8.START = 1'b1;
    bus8.A = a;
    bus8.B = b;
    @(posedge clk);
    #1 nb = bus8.BUSY ? 1 : 0;
    #1 bus8.START = 1'b0;
    bus8.A = 8'($urandom);
    bus8.B = 8'($urandom);
    n = 1;
    found = 1'b0;
    while (!found && n <= 20) begin
      @(posedge clk);
      #1;
      if (bus8.DONE) found = 1'b1;
      else begin
        if (bus8.BUSY) nb++;
        n++;
      end
      #1 bus8.A = 8'($urandom);
      bus8.B = 8'($urandom);
    end
    check({nm, "_seen"},    64'(found), 64'(1));
    check({nm, "_latency"}, 64'(n),     64'(8));
    check({nm, "_busycyc"}, 64'(nb),    64'(8));
    check({nm, "_sum"},     64'(bus8.SUM),  64'(es));
    check({nm, "_cout"},    64'(bus8.COUT), 64'(ec));
    check({nm, "_model"},   64'(m_res),     64'({ec, es}));
  endtask

  task automatic small_op(input int w, input int a, input int b);
    int n;
    bit found;
    logic [4:0] res;
    if (w == 4) begin
      bus4.START = 1'b1;
      bus4.A = 4'(a);
      bus4.B = 4'(b);
    end else begin
      bus1.START = 1'b1;
      bus1.A = 1'(a);
      bus1.B = 1'(b);
    end
    @(posedge clk);
    #2 bus4.START = 1'b0;
    bus1.START = 1'b0;
    bus4.A = 4'($urandom);
    bus1.A = 1'($urandom);
    n = 1;
    found = 1'b0;
    while (!found && n <= w + 5) begin
      @(posedge clk);
      #1;
      if ((w == 4) ? bus4.DONE : bus1.DONE) found = 1'b1;
      else n++;
      #1;
    end
    res = (w == 4) ? {bus4.COUT, bus4.SUM} : {3'b0, bus1.COUT, bus1.SUM};
    check($sformatf("w%0d_seen", w),    64'(found), 64'(1));
    check($sformatf("w%0d_latency", w), 64'(n),     64'(w));
    check($sformatf("w%0d_%0d+%0d", w, a, b), 64'(res), 64'(a + b));
  endtask

  initial begin
    #1200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int dones;
    int dn;
    int dt[2];
    logic [8:0] ds[2];
    logic b10;

    bus8.START = 1'b0; bus8.A = '0; bus8.B = '0;
    bus4.START = 1'b0; bus4.A = '0; bus4.B = '0;
    bus1.START = 1'b0; bus1.A = '0; bus1.B = '0;
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy8", 64'(bus8.BUSY), 64'(0));
    check("rst_done8", 64'(bus8.DONE), 64'(0));
    check("rst_sum8",  64'({bus8.COUT, bus8.SUM}), 64'(0));
    check("rst_w4",    64'({bus4.BUSY, bus4.DONE, bus4.COUT, bus4.SUM}), 64'(0));
    check("rst_w1",    64'({bus1.BUSY, bus1.DONE, bus1.COUT, bus1.SUM}), 64'(0));
    #1 rst = 1'b0;

    // START in the very first edge after reset release
    run8("zero", 8'h00, 8'h00, 8'h00, 1'b0);
    run8("ff_01", 8'hFF, 8'h01, 8'h00, 1'b1);
    run8("ff_ff", 8'hFF, 8'hFF, 8'hFE, 1'b1);
    run8("a5_5a", 8'hA5, 8'h5A, 8'hFF, 1'b0);

    // START during RUN is ignored
    @(posedge clk);
    #2 bus8.START = 1'b1; bus8.A = 8'h10; bus8.B = 8'h20;
    dones = 0; dn = 0; ds[0] = '0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #1;
      if (bus8.DONE) begin dones++; dn = i; ds[0] = {bus8.COUT, bus8.SUM}; end
      #1 bus8.START = (i == 2);
      if (i == 2) begin bus8.A = 8'hFF; bus8.B = 8'hFF; end
      else begin bus8.A = 8'($urandom); bus8.B = 8'($urandom); end
    end
    check("ign_dones", 64'(dones), 64'(1));
    check("ign_when",  64'(dn),    64'(9));
    check("ign_res",   64'(ds[0]), 64'(9'h030));

    // START held through FIN: back-to-back with no idle cycle
    bus8.START = 1'b1; bus8.A = 8'h05; bus8.B = 8'h06;
    dones = 0; b10 = 1'b0;
    for (int i = 1; i <= 25; i++) begin
      @(posedge clk);
      #1;
      if (i == 10) b10 = bus8.BUSY;
      if (bus8.DONE && dones < 2) begin dt[dones] = i; ds[dones] = {bus8.COUT, bus8.SUM}; end
      if (bus8.DONE) dones++;
      #1;
      if (i == 1) begin bus8.A = 8'h01; bus8.B = 8'h02; end
      if (i == 10) bus8.START = 1'b0;
    end
    check("b2b_dones", 64'(dones), 64'(2));
    check("b2b_noidle", 64'(b10), 64'(1));
    if (dones == 2) begin
      check("b2b_gap",  64'(dt[1] - dt[0]), 64'(9));
      check("b2b_res1", 64'(ds[0]), 64'(9'h00B));
      check("b2b_res2", 64'(ds[1]), 64'(9'h003));
    end

    // Reset in the middle of a run
    bus8.START = 1'b1; bus8.A = 8'hFF; bus8.B = 8'hFF;
    for (int i = 1; i <= 5; i++) begin
      @(posedge clk);
      #2 bus8.START = 1'b0;
    end
    rst = 1'b1;
    #1;
    check("arst_outs", 64'({bus8.BUSY, bus8.DONE, bus8.COUT, bus8.SUM}), 64'(0));
    @(posedge clk);
    #2 rst = 1'b0;
    dones = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1 if (bus8.DONE) dones++;
      #1;
    end
    check("arst_nodone", 64'(dones), 64'(0));
    run8("post_rst", 8'h03, 8'h04, 8'h07, 1'b0);

    // Exhaustive narrow widths
    for (int a = 0; a < 2; a++)
      for (int b = 0; b < 2; b++) small_op(1, a, b);
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++) small_op(4, a, b);

    // Random traffic on the 8-bit instance, checked cycle by cycle
    for (int c = 0; c < 800; c++) begin
      @(posedge clk);
      #2 bus8.START = ($urandom_range(0, 2) == 0);
      bus8.A = 8'($urandom);
      bus8.B = 8'($urandom);
    end
    bus8.START = 1'b0;
    repeat (12) @(posedge clk);
    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 Parameter WIDTH, default 8, operand width in bits; legal range 1..32.
REQ-002 CLK  input  1  single clock; all state updates on rising edge.
REQ-003 RST  input  1  reset, asynchronous, active-high.
REQ-004 START  input  1  request to begin an addition; sampled on CLK rising edge.
REQ-005 A  input  WIDTH  first operand; sampled only when START is accepted.
REQ-006 B  input  WIDTH  second operand; sampled only when START is accepted.
REQ-007 BUSY  output  1  high while an addition is in progress.
REQ-008 DONE  output  1  one-cycle pulse marking a completed result.
REQ-009 SUM  output  WIDTH  registered sum bits of the last completed addition.
REQ-010 COUT  output  1  registered carry-out of the last completed addition.

Function
REQ-011 The block SHALL add A and B bit-serially, LSB first, one bit per clock, using a full adder built from two half_adder instances plus an OR of their carries.
REQ-012 The FSM SHALL have states IDLE, RUN and FIN, all registered.
REQ-013 START SHALL be accepted in IDLE or FIN. On acceptance, A and B are latched into shift registers, the carry register is cleared, the bit counter is cleared, and the FSM moves to RUN.
REQ-014 START SHALL be ignored in RUN: no relatch, no restart, no change to the in-flight operands.
REQ-015 In RUN, each edge SHALL:
  - compute sum bit = a0^b0^carry;
  - shift the sum bit into the MSB of the result register;
  - shift the operand registers right by one;
  - update carry to the full-adder carry-out;
  - increment the bit counter.
REQ-016 On the edge that processes bit WIDTH-1, the block SHALL:
  - load SUM from the result register including the final bit;
  - load COUT from the final carry;
  - set DONE=1;
  - move the FSM to FIN.
REQ-017 Latency: with START accepted at edge k, DONE SHALL be high exactly in the cycle following edge k+WIDTH. For WIDTH=1 this is the cycle after edge k+1.
REQ-018 BUSY SHALL be 1 exactly while the FSM is in RUN.
REQ-019 DONE SHALL be 1 exactly while the FSM is in FIN.
REQ-020 From FIN, the FSM SHALL go to RUN if START=1, else to IDLE, so that back-to-back additions incur no idle cycle.
REQ-021 SUM and COUT SHALL hold their values from completion until the next completion or reset; they SHALL NOT change during RUN.
REQ-022 The result SHALL satisfy {COUT,SUM} = A + B modulo 2^(WIDTH+1) for all operand values, including all-ones + all-ones.
REQ-023 A and B changing while BUSY=1 SHALL have no effect on the result.

Reset
REQ-024 RST=1 SHALL immediately, independent of CLK:
  - force the FSM to IDLE;
  - clear BUSY, DONE, SUM, COUT, the carry, the bit counter and the shift registers.
REQ-025 Reset asserted mid-RUN SHALL abort the operation; no DONE pulse SHALL follow.
REQ-026 START high in the first edge after RST deasserts SHALL be accepted normally.

Structure
REQ-027 State encodings (IDLE=0, RUN=1, FIN=2) and the default WIDTH SHALL live in the shared adder definitions package/include, not be redefined locally.
REQ-028 The existing half_adder module SHALL be the only sub-module, instantiated twice. Full-adder glue and the FSM SHALL reside in serial_adder.
REQ-029 The bit counter SHALL be $clog2(WIDTH+1) bits wide, minimum 1.

Verification
REQ-030 WIDTH=8, A=0x00, B=0x00, START one cycle -> BUSY high 8 cycles, then DONE for one cycle with SUM=0x00, COUT=0.
REQ-031 WIDTH=8, A=0xFF, B=0x01 -> SUM=0x00, COUT=1. A=0xFF, B=0xFF -> SUM=0xFE, COUT=1. A=0xA5, B=0x5A -> SUM=0xFF, COUT=0.
REQ-032 WIDTH=8, START with A=0x10, B=0x20, then START with A=0xFF, B=0xFF at cycle 3 and A, B toggled during RUN -> single DONE, SUM=0x30, COUT=0.
REQ-033 WIDTH=8, START held high through FIN with new A=0x01, B=0x02 -> the second addition begins with no IDLE cycle. DONE pulses 9 cycles apart; the second result is SUM=0x03.
REQ-034 RST pulsed at bit 4 of A=0xFF, B=0xFF -> all outputs 0 immediately and no DONE. A following START with A=0x03, B=0x04 -> SUM=0x07, COUT=0.
REQ-035 WIDTH=1 and WIDTH=4, exhaustive A and B -> every {COUT,SUM} equals A+B, with DONE exactly WIDTH cycles after the accepting edge.
